fmap_stream_reader: RTL and testbench
=====================================

FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one feature-map element.
REQ-002 SHALL have parameter IFM_SIZE_NEXT, default 10: side length of each square map.
REQ-003 SHALL have parameter NUMBER_OF_IFM_NEXT, default 2: number of maps (banks) per frame.
REQ-004 SHALL derive ADDRESS_SIZE_NEXT_IFM = clog2(IFM_SIZE_NEXT^2) and SEL_BITS = max(1, clog2(NUMBER_OF_IFM_NEXT)).
REQ-005 Ports SHALL be as follows (one clock; reset is synchronous and active-high):
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous active-high reset
  start_from_previous  in  1  one-cycle pulse: frame written, begin reading
  end_to_previous  out  1  high = idle, writer may start a new frame
  ifm_sel  out  SEL_BITS  bank select of the map being read
  ifm_enable_read  out  1  memory read strobe
  ifm_address_read  out  ADDRESS_SIZE_NEXT_IFM  read address
  ifm_data_in  in  DATA_WIDTH  memory data, valid the cycle after the strobe
  data_out  out  DATA_WIDTH  streamed element
  data_valid  out  1  data_out valid
  data_ready  in  1  consumer accepts when valid & ready
  last_out  out  1  qualifies the final element of the frame

Function
REQ-006 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-007 IDLE: end_to_previous=1; start_from_previous=1 -> READ next cycle, address and ifm_sel cleared.
REQ-008 start_from_previous outside IDLE SHALL be ignored, with no state or counter change.
REQ-009 READ: end_to_previous=0; ifm_enable_read=1 only when output-buffer occupancy plus in-flight reads < 2.
REQ-010 On each issued read, address SHALL increment; at IFM_SIZE_NEXT^2-1 it wraps to 0 and ifm_sel increments.
REQ-011 Read issued with ifm_sel=NUMBER_OF_IFM_NEXT-1 and final address SHALL move FSM to DRAIN and mark that element last.
REQ-012 DRAIN: no reads; -> IDLE the cycle after the last element is accepted (valid & ready).
REQ-013 ifm_data_in SHALL be captured into a 2-entry output FIFO the cycle after the strobe; data_valid = FIFO non-empty.
REQ-014 With data_ready held 1, SHALL sustain one element per cycle; first data_valid two cycles after the first strobe.
REQ-015 data_out/last_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-016 Frame length SHALL be exactly NUMBER_OF_IFM_NEXT*IFM_SIZE_NEXT^2 elements, in order, no loss or duplication.
REQ-017 ifm_enable_read=0 in IDLE and DRAIN; ifm_address_read/ifm_sel hold their last value when not reading.

Reset
REQ-018 Reset SHALL take effect at the next rising clk edge regardless of state, aborting any frame.
REQ-019 Reset values: state IDLE, end_to_previous=1, ifm_enable_read=0, ifm_address_read=0, ifm_sel=0, FIFO empty, data_valid=0, last_out=0, data_out=0.
REQ-020 Read data returning the cycle after reset SHALL be discarded.

Configuration
REQ-021 With FMAP_RD_POOL_ORDER_EN defined, addresses SHALL follow 2x2-window order (r,c),(r,c+1),(r+1,c),(r+1,c+1), windows raster-ordered; IFM_SIZE_NEXT must be even (elaboration error otherwise).
REQ-022 Without FMAP_RD_POOL_ORDER_EN, addresses SHALL be plain raster 0..IFM_SIZE_NEXT^2-1.

Structure
REQ-023 FSM state encoding and address-width helper functions SHALL live in shared package lenet_pkg.
REQ-024 The 2-entry FIFO SHALL be a sub-module, skid_fifo2 (DATA_WIDTH+1 bits wide: data plus last).

Verification
REQ-025 Defaults, data_ready=1, start pulse at cycle 0 -> strobe at cycle 1 addr 0; 200 elements with last_out on the 200th; end_to_previous returns 1.
REQ-026 data_ready toggled 1/0 per cycle -> same 200 values in order; never more than 2 reads outstanding beyond accepted data.
REQ-027 Extra start pulse mid-frame -> ignored; exactly 200 elements delivered.
REQ-028 Reset asserted at element 57 -> next cycle all outputs at reset values; a new start yields a full 200-element frame.
REQ-029 FMAP_RD_POOL_ORDER_EN, IFM_SIZE_NEXT=4 -> address sequence 0,1,4,5,2,3,6,7,8,9,12,13,...
REQ-030 data_ready=0 for 20 cycles after start -> exactly 2 strobes issued, data_out stable on the first element.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared FSM encoding and width helpers for the LeNet feature-map datapath.
package lenet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } fmap_rd_state_e;

    function automatic int ifm_addr_bits(input int side);
        return (side * side > 1) ? $clog2(side * side) : 1;
    endfunction

    function automatic int ifm_sel_bits(input int maps);
        return (maps > 1) ? $clog2(maps) : 1;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output FIFO. The oldest entry always sits in head_r, so the
// consumer sees data straight from a flop and it cannot change while stalled.
module skid_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;
    logic             pop_s;
    logic             push_s;

    // Qualify requests against the current occupancy.
    always_comb begin
        pop_s  = pop && (count_r != 2'd0);
        push_s = push && ((count_r != 2'd2) || pop_s);
    end

    // Storage update: on a pop the tail slides forward into the head slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head      = head_r;
    assign not_empty = (count_r != 2'd0);
    assign count     = count_r;

endmodule

// File: rtl/fmap_stream_reader.sv
// Streams a frame of NUMBER_OF_IFM_NEXT square maps out of bank memory.
// Define FMAP_RD_POOL_ORDER_EN to read each map in 2x2-window order instead of raster order.
module fmap_stream_reader
    import lenet_pkg::*;
#(
    parameter int  DATA_WIDTH            = 32,
    parameter int  IFM_SIZE_NEXT         = 10,
    parameter int  NUMBER_OF_IFM_NEXT    = 2,
    localparam int ADDRESS_SIZE_NEXT_IFM = ifm_addr_bits(IFM_SIZE_NEXT),
    localparam int SEL_BITS              = ifm_sel_bits(NUMBER_OF_IFM_NEXT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    output logic                             end_to_previous,
    output logic [SEL_BITS-1:0]              ifm_sel,
    output logic                             ifm_enable_read,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_read,
    input  logic [DATA_WIDTH-1:0]            ifm_data_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_valid,
    input  logic                             data_ready,
    output logic                             last_out
);

    localparam int AW = ADDRESS_SIZE_NEXT_IFM;
    localparam logic [AW-1:0]       LAST_ADDR = AW'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    localparam logic [SEL_BITS-1:0] LAST_SEL  = SEL_BITS'(NUMBER_OF_IFM_NEXT - 1);

    fmap_rd_state_e        state_r;
    fmap_rd_state_e        state_nxt_s;
    logic [SEL_BITS-1:0]   sel_r;
    logic [AW-1:0]         addr_s;
    logic                  issue_s;
    logic                  last_issue_s;
    logic                  room_s;
    logic                  pop_s;
    logic [2:0]            level_s;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic [DATA_WIDTH:0]   fifo_head_s;
    logic                  fifo_valid_s;
    logic [1:0]            fifo_count_s;

`ifdef FMAP_RD_POOL_ORDER_EN
    localparam int            HALF      = IFM_SIZE_NEXT / 2;
    localparam logic [AW-1:0] HALF_LAST = AW'(HALF - 1);
    localparam logic [AW-1:0] SIDE      = AW'(IFM_SIZE_NEXT);

    logic [1:0]    sub_r;
    logic [AW-1:0] wc_r;
    logic [AW-1:0] wr_r;

    if (IFM_SIZE_NEXT % 2 != 0) begin : g_odd_side
        $error("fmap_stream_reader: 2x2 window order needs an even IFM_SIZE_NEXT");
    end

    // Window row/column plus position inside the window rebuild the linear address.
    always_comb begin
        addr_s = (((wr_r << 1) + AW'(sub_r[1])) * SIDE) + (wc_r << 1) + AW'(sub_r[0]);
    end

    // Walk the four window positions, then windows in raster order, then banks.
    always_ff @(posedge clk) begin
        if (reset || (state_r == ST_IDLE && start_from_previous)) begin
            sub_r <= 2'd0;
            wc_r  <= '0;
            wr_r  <= '0;
            sel_r <= '0;
        end else if (issue_s && !last_issue_s) begin
            sub_r <= sub_r + 2'd1;
            if (sub_r == 2'd3) begin
                if (wc_r == HALF_LAST) begin
                    wc_r <= '0;
                    if (wr_r == HALF_LAST) begin
                        wr_r  <= '0;
                        sel_r <= sel_r + SEL_BITS'(1);
                    end else begin
                        wr_r <= wr_r + AW'(1);
                    end
                end else begin
                    wc_r <= wc_r + AW'(1);
                end
            end
        end
    end
`else
    logic [AW-1:0] addr_r;

    always_comb begin
        addr_s = addr_r;
    end

    // Raster address walk; the bank select advances when a map wraps.
    always_ff @(posedge clk) begin
        if (reset || (state_r == ST_IDLE && start_from_previous)) begin
            addr_r <= '0;
            sel_r  <= '0;
        end else if (issue_s && !last_issue_s) begin
            if (addr_r == LAST_ADDR) begin
                addr_r <= '0;
                sel_r  <= sel_r + SEL_BITS'(1);
            end else begin
                addr_r <= addr_r + AW'(1);
            end
        end
    end
`endif

    // Credit check: a pop this cycle frees a slot, which keeps one element per cycle flowing.
    always_comb begin
        pop_s        = fifo_valid_s & data_ready;
        level_s      = 3'(fifo_count_s) + {2'b00, inflight_r} - {2'b00, pop_s};
        room_s       = (level_s < 3'd2);
        last_issue_s = issue_s && (sel_r == LAST_SEL) && (addr_s == LAST_ADDR);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_from_previous) state_nxt_s = ST_READ;
                else                     state_nxt_s = ST_IDLE;
            end
            ST_READ: begin
                if (last_issue_s) state_nxt_s = ST_DRAIN;
                else              state_nxt_s = ST_READ;
            end
            ST_DRAIN: begin
                if (pop_s && fifo_head_s[DATA_WIDTH]) state_nxt_s = ST_IDLE;
                else                                   state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        end_to_previous = 1'b0;
        ifm_enable_read = 1'b0;
        case (state_r)
            ST_IDLE:  end_to_previous = 1'b1;
            ST_READ:  ifm_enable_read = room_s;
            ST_DRAIN: ifm_enable_read = 1'b0;
            default:  end_to_previous = 1'b1;
        endcase
    end

    assign issue_s = ifm_enable_read;

    // Memory returns data one cycle after the strobe; a reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
        end
    end

    skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_r),
        .push_data ({inflight_last_r, ifm_data_in}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .not_empty (fifo_valid_s),
        .count     (fifo_count_s)
    );

    assign ifm_sel          = sel_r;
    assign ifm_address_read = addr_s;
    assign data_out         = fifo_head_s[DATA_WIDTH-1:0];
    assign data_valid       = fifo_valid_s;
    assign last_out         = fifo_head_s[DATA_WIDTH] & fifo_valid_s;

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Self-checking bench for fmap_stream_reader: scenario table plus hand-written reset/stall sequences.
module tb_fmap_stream_reader;

    localparam int DW    = 32;
    localparam int S     = 10;
    localparam int N     = 2;
    localparam int SQ    = S * S;
    localparam int FRAME = N * SQ;
    localparam int AW    = $clog2(SQ);
    localparam int SB    = 1;

    typedef struct {
        int ready_mode;        // 0 always ready, 1 toggling, 2 random
        int extra_start;       // loop cycle of a spurious start pulse, -1 for none
        int stall_cyc;         // ready held low for this many cycles after start
        int exp_cycles;        // expected cycles until idle again, 0 = not checked
        int exp_stall_strobes; // strobes expected while stalled
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_from_previous;
    logic          end_to_previous;
    logic [SB-1:0] ifm_sel;
    logic          ifm_enable_read;
    logic [AW-1:0] ifm_address_read;
    logic [DW-1:0] ifm_data_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          last_out;

    int n_pass  = 0;
    int n_total = 0;
    int strobe_k, rx_k, last_cnt, max_out, cur_cyc, first_strobe, first_valid, end_cyc;
    logic          hold_pend;
    logic [DW-1:0] held_data;
    logic          held_last;
    vec_t          tbl[6];

    always #5 clk = ~clk;

    fmap_stream_reader #(
        .DATA_WIDTH         (DW),
        .IFM_SIZE_NEXT      (S),
        .NUMBER_OF_IFM_NEXT (N)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_from_previous (start_from_previous),
        .end_to_previous     (end_to_previous),
        .ifm_sel             (ifm_sel),
        .ifm_enable_read     (ifm_enable_read),
        .ifm_address_read    (ifm_address_read),
        .ifm_data_in         (ifm_data_in),
        .data_out            (data_out),
        .data_valid          (data_valid),
        .data_ready          (data_ready),
        .last_out            (last_out)
    );

    function automatic logic [DW-1:0] mem_val(input int sel, input int addr);
        return 32'h5A00_0000 ^ (32'(sel) << 16) ^ (32'(addr) * 32'd257);
    endfunction

    // k-th address within one map, straight from the ordering rule.
    function automatic int exp_addr(input int k);
`ifdef FMAP_RD_POOL_ORDER_EN
        int w;
        int sub;
        int half;
        half = S / 2;
        w    = k / 4;
        sub  = k % 4;
        return (2 * (w / half) + sub / 2) * S + 2 * (w % half) + sub % 2;
`else
        return k;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data(input int k);
        return mem_val(k / SQ, exp_addr(k % SQ));
    endfunction

    // Bank memory: registered read, garbage when not strobed.
    always @(posedge clk) begin
        if (ifm_enable_read) ifm_data_in <= mem_val(int'(ifm_sel), int'(ifm_address_read));
        else                 ifm_data_in <= $urandom();
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic monitor();
        int outstanding;
        if (ifm_enable_read) begin
            if (strobe_k == 0) first_strobe = cur_cyc;
            if (strobe_k < FRAME)
                check("strobe_addr", {32'(ifm_sel), 32'(ifm_address_read)},
                      {32'(strobe_k / SQ), 32'(exp_addr(strobe_k % SQ))});
            else
                check("strobe_count", 64'(strobe_k), 64'(FRAME - 1));
            strobe_k++;
        end
        if (data_valid && first_valid < 0) first_valid = cur_cyc;
        if (hold_pend)
            check("hold_stable", {30'd0, data_valid, last_out, data_out}, {30'd0, 1'b1, held_last, held_data});
        hold_pend = data_valid && !data_ready;
        held_data = data_out;
        held_last = last_out;
        if (data_valid && data_ready) begin
            if (rx_k < FRAME)
                check("elem", {31'd0, last_out, data_out}, {31'd0, (rx_k == FRAME - 1), exp_data(rx_k)});
            else
                check("rx_count", 64'(rx_k), 64'(FRAME - 1));
            if (last_out) last_cnt++;
            rx_k++;
        end
        outstanding = strobe_k - rx_k;
        if (outstanding > max_out) max_out = outstanding;
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        strobe_k     = 0;
        rx_k         = 0;
        last_cnt     = 0;
        max_out      = 0;
        hold_pend    = 1'b0;
        first_strobe = -1;
        first_valid  = -1;
        end_cyc      = -1;
        cur_cyc      = -1;
    endtask

    task automatic check_reset_values(input string name);
        @(negedge clk);
        check(name, {20'd0, end_to_previous, ifm_enable_read, ifm_address_read, ifm_sel,
                     data_valid, last_out, data_out},
              {20'd0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 32'd0});
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        clear_model();
        data_ready          = 1'b1;
        start_from_previous = 1'b1;
        cycle();
        start_from_previous = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (rx_k == FRAME && end_to_previous) begin
                end_cyc = cyc;
                break;
            end
            if (v.stall_cyc > 0 && cyc == v.stall_cyc) begin
                check("stall_strobes", 64'(strobe_k), 64'(v.exp_stall_strobes));
                check("stall_head", {31'd0, data_valid, data_out}, {31'd0, 1'b1, exp_data(0)});
            end
            case (v.ready_mode)
                1:       data_ready = (cyc % 2 == 0);
                2:       data_ready = ($urandom_range(0, 3) != 0);
                default: data_ready = 1'b1;
            endcase
            if (cyc < v.stall_cyc) data_ready = 1'b0;
            start_from_previous = (cyc == v.extra_start);
            cur_cyc = cyc;
            cycle();
        end
        start_from_previous = 1'b0;
        check("frame_len", 64'(rx_k), 64'(FRAME));
        check("frame_strobes", 64'(strobe_k), 64'(FRAME));
        check("last_count", 64'(last_cnt), 64'd1);
        check("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        check("end_to_previous", 64'(end_to_previous), 64'd1);
        check("first_strobe_cyc", 64'(first_strobe), 64'd0);
        check("first_valid_latency", 64'(first_valid - first_strobe), 64'd2);
        if (v.exp_cycles > 0) check("frame_cycles", 64'(end_cyc), 64'(v.exp_cycles));
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("idle_no_read", {62'd0, ifm_enable_read, data_valid}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{ready_mode: 0, extra_start: -1, stall_cyc: 0,  exp_cycles: FRAME + 2,  exp_stall_strobes: 0};
        tbl[1] = '{ready_mode: 1, extra_start: -1, stall_cyc: 0,  exp_cycles: 0,          exp_stall_strobes: 0};
        tbl[2] = '{ready_mode: 0, extra_start: 50, stall_cyc: 0,  exp_cycles: FRAME + 2,  exp_stall_strobes: 0};
        tbl[3] = '{ready_mode: 0, extra_start: -1, stall_cyc: 20, exp_cycles: FRAME + 20, exp_stall_strobes: 2};
        tbl[4] = '{ready_mode: 2, extra_start: -1, stall_cyc: 0,  exp_cycles: 0,          exp_stall_strobes: 0};
        tbl[5] = '{ready_mode: 2, extra_start: 7,  stall_cyc: 0,  exp_cycles: 0,          exp_stall_strobes: 0};

        clear_model();
        reset               = 1'b1;
        start_from_previous = 1'b0;
        data_ready          = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        check_reset_values("reset_state");

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Abort a frame once 57 elements have been accepted.
        clear_model();
        data_ready          = 1'b1;
        start_from_previous = 1'b1;
        cycle();
        start_from_previous = 1'b0;
        for (int i = 0; i < 500 && rx_k < 57; i++) cycle();
        check("pre_abort_count", 64'(rx_k), 64'd57);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_values("abort_reset_state");
        run_vec(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
